// File: rtl/cjb_risc_cu_pkg.sv
// Shared definitions for the cjb_risc Harvard control unit.
// Contents:
//   - opcode constants (IW[7:4])
//   - ALU function-select codes
//   - state encoding
//   - IB2 write-back select codes
//   - opcode -> ALU_FS mapping helper
package cjb_risc_cu_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_CPY  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_ADDK = 4'hA;
    localparam logic [3:0] OP_PUSH = 4'hB;
    localparam logic [3:0] OP_POP  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_IN   = 4'hE;
    localparam logic [3:0] OP_OUT  = 4'hF;

    // ALU function selects
    localparam logic [3:0] FS_ADD  = 4'h0;
    localparam logic [3:0] FS_SUB  = 4'h1;
    localparam logic [3:0] FS_AND  = 4'h2;
    localparam logic [3:0] FS_OR   = 4'h3;
    localparam logic [3:0] FS_XOR  = 4'h4;
    localparam logic [3:0] FS_NOT  = 4'h5;
    localparam logic [3:0] FS_ADDK = 4'h6;

    // IB2 write-back sources
    localparam logic [1:0] IB2_IB0 = 2'd0;
    localparam logic [1:0] IB2_ALU = 2'd1;
    localparam logic [1:0] IB2_DM  = 2'd2;
    localparam logic [1:0] IB2_STK = 2'd3;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EX1    = 3'd3,
        ST_EX2    = 3'd4
    } state_t;

    function automatic logic [3:0] alu_fs_of(input logic [3:0] op);
        logic [3:0] fs;
        fs = FS_ADD;
        case (op)
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  fs = FS_SUB;
            OP_AND:  fs = FS_AND;
            OP_OR:   fs = FS_OR;
            OP_XOR:  fs = FS_XOR;
            OP_NOT:  fs = FS_NOT;
            OP_ADDK: fs = FS_ADDK;
            default: fs = FS_ADD;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/cjb_2to4_ld_dec.sv
// 2-to-4 register-load decoder.
// Ports:
//   en  in  1  load enable; all outputs 0 when low
//   sel in  2  register index
//   ld  out 4  one-hot load strobe, bit n loads Rn
module cjb_2to4_ld_dec (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] ld
);
    always_comb begin
        ld = 4'b0000;
        if (en) begin
            ld[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/cjb_risc_hmmiop_cu.sv
// Multi-cycle control unit for the 3-bus Harvard datapath with
// memory-mapped I/O ports. Sequences RST -> FETCH -> DECODE (-> EX1 -> EX2)
// and drives all datapath load/select/memory/stack controls.
// Ports:
//   Clock, Reset           clock and synchronous active-high reset
//   IW[7:0]                instruction word from IR
//   SR_CNVZ[3:0]           status flags {C,N,V,Z}
//   RST_PC/LD_PC/CNT_PC    PC controls
//   LD_IR, LD_R0..LD_R3    IR and register-file loads
//   LD_SR, LD_MABR, LD_MAXR, LD_MAR   status and address-path loads
//   RW                     data memory write enable
//   LD_IPDR, LD_OPDR       I/O register loads
//   IB0_SEL, IB1_SEL       bus register selects
//   IB2_SEL                write-back source select
//   ALU_FS                 ALU function select
//   push, pop, ipstksel    stack controls
//   state_o                current state
module cjb_risc_hmmiop_cu
    import cjb_risc_cu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] IW,
    input  logic [3:0] SR_CNVZ,
    output logic       RST_PC,
    output logic       LD_PC,
    output logic       CNT_PC,
    output logic       LD_IR,
    output logic       LD_R0,
    output logic       LD_R1,
    output logic       LD_R2,
    output logic       LD_R3,
    output logic       LD_SR,
    output logic       LD_MABR,
    output logic       LD_MAXR,
    output logic       LD_MAR,
    output logic       RW,
    output logic       LD_IPDR,
    output logic       LD_OPDR,
    output logic [1:0] IB0_SEL,
    output logic [1:0] IB1_SEL,
    output logic [1:0] IB2_SEL,
    output logic [3:0] ALU_FS,
    output logic       push,
    output logic       pop,
    output logic       ipstksel,
    output logic [2:0] state_o
);

    state_t     state, next_state;
    logic       ld_en;
    logic [3:0] ld_vec;
    logic [3:0] opcode;
    logic [1:0] ri, rj;

    assign opcode = IW[7:4];
    assign ri     = IW[3:2];
    assign rj     = IW[1:0];

    // Condition 0 is unconditional; otherwise any selected flag set takes the jump.
    function automatic logic jmp_taken(input logic [3:0] c, input logic [3:0] sr);
        return (c == 4'b0000) || ((c & sr) != 4'b0000);
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_RST;
        else       state <= next_state;
    end

    always_comb begin
        next_state = ST_FETCH;
        RST_PC   = 1'b0;
        LD_PC    = 1'b0;
        CNT_PC   = 1'b0;
        LD_IR    = 1'b0;
        LD_SR    = 1'b0;
        LD_MABR  = 1'b0;
        LD_MAXR  = 1'b0;
        LD_MAR   = 1'b0;
        RW       = 1'b0;
        LD_IPDR  = 1'b0;
        LD_OPDR  = 1'b0;
        IB0_SEL  = 2'd0;
        IB1_SEL  = 2'd0;
        IB2_SEL  = IB2_IB0;
        ALU_FS   = 4'h0;
        push     = 1'b0;
        pop      = 1'b0;
        ipstksel = 1'b0;
        ld_en    = 1'b0;

        case (state)
            ST_RST: begin
                RST_PC     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                LD_IPDR    = 1'b1;
                LD_IR      = 1'b1;
                CNT_PC     = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                LD_IPDR    = 1'b1;
                next_state = ST_FETCH;
                case (opcode)
                    OP_LD, OP_ST: begin
                        // Index register goes to MAXR while the address word
                        // (already on the PM bus) goes to MABR; PC skips it.
                        LD_MABR    = 1'b1;
                        LD_MAXR    = 1'b1;
                        IB0_SEL    = rj;
                        IB2_SEL    = IB2_IB0;
                        CNT_PC     = 1'b1;
                        next_state = ST_EX1;
                    end
                    OP_JMP: begin
                        LD_MABR    = 1'b1;
                        LD_MAXR    = 1'b1;
                        CNT_PC     = 1'b1;
                        next_state = ST_EX1;
                    end
                    OP_CPY: begin
                        IB0_SEL = rj;
                        IB2_SEL = IB2_IB0;
                        ld_en   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDK: begin
                        IB0_SEL = ri;
                        IB1_SEL = rj;
                        ALU_FS  = alu_fs_of(opcode);
                        IB2_SEL = IB2_ALU;
                        ld_en   = 1'b1;
                        LD_SR   = 1'b1;
                    end
                    OP_PUSH: begin
                        IB0_SEL = ri;
                        IB2_SEL = IB2_IB0;
                        push    = 1'b1;
                    end
                    OP_POP: begin
                        pop      = 1'b1;
                        ipstksel = 1'b0;
                        IB2_SEL  = IB2_STK;
                        ld_en    = 1'b1;
                    end
                    OP_IN: begin
                        ipstksel = 1'b1;
                        IB2_SEL  = IB2_STK;
                        ld_en    = 1'b1;
                    end
                    OP_OUT: begin
                        IB0_SEL = ri;
                        IB2_SEL = IB2_IB0;
                        LD_OPDR = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_EX1: begin
                LD_IPDR    = 1'b1;
                LD_MAR     = 1'b1;
                next_state = ST_EX2;
            end
            ST_EX2: begin
                LD_IPDR    = 1'b1;
                next_state = ST_FETCH;
                case (opcode)
                    OP_LD: begin
                        IB2_SEL = IB2_DM;
                        ld_en   = 1'b1;
                    end
                    OP_ST: begin
                        IB0_SEL = ri;
                        IB2_SEL = IB2_IB0;
                        RW      = 1'b1;
                    end
                    OP_JMP: begin
                        LD_PC = jmp_taken(IW[3:0], SR_CNVZ);
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    cjb_2to4_ld_dec u_ld_dec (
        .en  (ld_en),
        .sel (ri),
        .ld  (ld_vec)
    );

    assign LD_R0   = ld_vec[0];
    assign LD_R1   = ld_vec[1];
    assign LD_R2   = ld_vec[2];
    assign LD_R3   = ld_vec[3];
    assign state_o = state;

endmodule

// File: tb/tb_cjb_risc_hmmiop_cu.sv
// Directed testbench for cjb_risc_hmmiop_cu. All outputs are packed into a
// struct and compared as a whole against hand-built expected values.
module tb_cjb_risc_hmmiop_cu;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] IW;
    logic [3:0] SR_CNVZ;
    logic       RST_PC, LD_PC, CNT_PC, LD_IR;
    logic       LD_R0, LD_R1, LD_R2, LD_R3;
    logic       LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR;
    logic [1:0] IB0_SEL, IB1_SEL, IB2_SEL;
    logic [3:0] ALU_FS;
    logic       push, pop, ipstksel;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst_pc;
        logic       ld_pc;
        logic       cnt_pc;
        logic       ld_ir;
        logic [3:0] ld_r;
        logic       ld_sr;
        logic       ld_mabr;
        logic       ld_maxr;
        logic       ld_mar;
        logic       rw;
        logic       ld_ipdr;
        logic       ld_opdr;
        logic [1:0] ib0;
        logic [1:0] ib1;
        logic [1:0] ib2;
        logic [3:0] fs;
        logic       push;
        logic       pop;
        logic       ips;
    } outs_t;

    outs_t act, e;

    assign act = {RST_PC, LD_PC, CNT_PC, LD_IR, {LD_R3, LD_R2, LD_R1, LD_R0},
                  LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR,
                  IB0_SEL, IB1_SEL, IB2_SEL, ALU_FS, push, pop, ipstksel};

    cjb_risc_hmmiop_cu dut (
        .Clock(Clock), .Reset(Reset), .IW(IW), .SR_CNVZ(SR_CNVZ),
        .RST_PC(RST_PC), .LD_PC(LD_PC), .CNT_PC(CNT_PC), .LD_IR(LD_IR),
        .LD_R0(LD_R0), .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3),
        .LD_SR(LD_SR), .LD_MABR(LD_MABR), .LD_MAXR(LD_MAXR), .LD_MAR(LD_MAR),
        .RW(RW), .LD_IPDR(LD_IPDR), .LD_OPDR(LD_OPDR),
        .IB0_SEL(IB0_SEL), .IB1_SEL(IB1_SEL), .IB2_SEL(IB2_SEL),
        .ALU_FS(ALU_FS), .push(push), .pop(pop), .ipstksel(ipstksel),
        .state_o(state_o)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outputs in any non-reset state with nothing else active.
    function automatic outs_t idle();
        outs_t o;
        o = '0;
        o.ld_ipdr = 1'b1;
        return o;
    endfunction

    // Advance one clock and compare state and full output vector.
    task automatic step(input string tag, input logic [2:0] st, input outs_t exp);
        @(posedge Clock);
        #1;
        check({tag, ".state"}, {29'd0, state_o}, {29'd0, st});
        check({tag, ".outs"}, {4'd0, act}, {4'd0, exp});
    endtask

    function automatic outs_t fetch_e();
        outs_t o;
        o = idle();
        o.ld_ir  = 1'b1;
        o.cnt_pc = 1'b1;
        return o;
    endfunction

    function automatic outs_t addr_e(input logic [1:0] rj);
        outs_t o;
        o = idle();
        o.ld_mabr = 1'b1;
        o.ld_maxr = 1'b1;
        o.cnt_pc  = 1'b1;
        o.ib0     = rj;
        return o;
    endfunction

    function automatic outs_t mar_e();
        outs_t o;
        o = idle();
        o.ld_mar = 1'b1;
        return o;
    endfunction

    task automatic jmp(input string tag, input logic [7:0] iw, input logic [3:0] sr, input logic taken);
        outs_t o;
        IW = iw;
        SR_CNVZ = sr;
        step({tag, ".dec"}, 3'd2, addr_e(2'd0));
        step({tag, ".ex1"}, 3'd3, mar_e());
        o = idle();
        o.ld_pc = taken;
        step({tag, ".ex2"}, 3'd4, o);
        step({tag, ".fetch"}, 3'd1, fetch_e());
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        IW = 8'h00;
        SR_CNVZ = 4'h0;

        // Reset held 2 cycles
        e = '0;
        e.rst_pc = 1'b1;
        step("rst0", 3'd0, e);
        step("rst1", 3'd0, e);
        Reset = 1'b0;
        step("fetch0", 3'd1, fetch_e());

        // ADD R1,R2
        IW = 8'h46;
        e = idle();
        e.ib0 = 2'd1; e.ib1 = 2'd2; e.fs = 4'h0; e.ib2 = 2'd1;
        e.ld_r = 4'b0010; e.ld_sr = 1'b1;
        step("add.dec", 3'd2, e);
        step("add.fetch", 3'd1, fetch_e());

        // LD R2,[R3+M]
        IW = 8'h1B;
        step("ld.dec", 3'd2, addr_e(2'd3));
        step("ld.ex1", 3'd3, mar_e());
        e = idle();
        e.ib2 = 2'd2; e.ld_r = 4'b0100;
        step("ld.ex2", 3'd4, e);
        step("ld.fetch", 3'd1, fetch_e());

        // Conditional jumps
        jmp("jz_t",  8'hD1, 4'b0001, 1'b1);
        jmp("jz_nt", 8'hD1, 4'b1110, 1'b0);
        jmp("jmp_u", 8'hD0, 4'b0000, 1'b1);
        jmp("jc_t",  8'hD8, 4'b1000, 1'b1);

        // ST R1,[R0+M]
        IW = 8'h24;
        step("st.dec", 3'd2, addr_e(2'd0));
        step("st.ex1", 3'd3, mar_e());
        e = idle();
        e.rw = 1'b1; e.ib0 = 2'd1; e.ib2 = 2'd0;
        step("st.ex2", 3'd4, e);
        step("st.fetch", 3'd1, fetch_e());

        // PUSH R2
        IW = 8'hB8;
        e = idle();
        e.push = 1'b1; e.ib0 = 2'd2;
        step("push.dec", 3'd2, e);
        step("push.fetch", 3'd1, fetch_e());

        // POP R1
        IW = 8'hC4;
        e = idle();
        e.pop = 1'b1; e.ib2 = 2'd3; e.ld_r = 4'b0010;
        step("pop.dec", 3'd2, e);
        step("pop.fetch", 3'd1, fetch_e());

        // CPY R1,R2
        IW = 8'h36;
        e = idle();
        e.ib0 = 2'd2; e.ld_r = 4'b0010;
        step("cpy.dec", 3'd2, e);
        step("cpy.fetch", 3'd1, fetch_e());

        // SUB R3,R0
        IW = 8'h5C;
        e = idle();
        e.ib0 = 2'd3; e.ib1 = 2'd0; e.fs = 4'h1; e.ib2 = 2'd1;
        e.ld_r = 4'b1000; e.ld_sr = 1'b1;
        step("sub.dec", 3'd2, e);
        step("sub.fetch", 3'd1, fetch_e());

        // OUT R3
        IW = 8'hFC;
        e = idle();
        e.ib0 = 2'd3; e.ld_opdr = 1'b1;
        step("out.dec", 3'd2, e);
        step("out.fetch", 3'd1, fetch_e());

        // NOP
        IW = 8'h00;
        step("nop.dec", 3'd2, idle());
        step("nop.fetch", 3'd1, fetch_e());

        // Reset during EX1 of LD aborts the instruction
        IW = 8'h1B;
        step("ldr.dec", 3'd2, addr_e(2'd3));
        step("ldr.ex1", 3'd3, mar_e());
        Reset = 1'b1;
        e = '0;
        e.rst_pc = 1'b1;
        step("ldr.rst", 3'd0, e);
        Reset = 1'b0;
        step("ldr.fetch", 3'd1, fetch_e());

        // IN R3
        IW = 8'hEC;
        e = idle();
        e.ips = 1'b1; e.ib2 = 2'd3; e.ld_r = 4'b1000;
        step("in.dec", 3'd2, e);
        step("in.fetch", 3'd1, fetch_e());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
